program_counter: RTL and testbench
==================================

# program_counter

Program counter for the single-cycle CPU. It holds the current instruction byte address and presents it to instruction memory on `ins_addr`. Every clock it loads one of three values: the sequential address PC+4, a PC-relative branch target, or an absolute jump target. It sits at the front of the datapath. The branch and jump decisions come from the control and ALU-zero logic, and the offset and target come from the decode stage.

## Interface
Parameters:
- `RESET_ADDR`, default 32'h0000_0000: value loaded into the PC on reset.
- `INCR`, default 32'd4: sequential increment, in bytes.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: reset, asynchronous and active-low. Low forces the PC to `RESET_ADDR` immediately.
- `branch`, input, 1: take a PC-relative branch this cycle.
- `offset`, input, 32: sign-extended branch word offset, in instructions.
- `jump`, input, 1: take an absolute jump this cycle.
- `target`, input, 32: absolute jump byte address.
- `ins_addr`, output, 32: current instruction address, equal to the PC register.

Implementation constraint: the state register must be a 32-bit `reg` named `pc` at the top level of the module, because benches preload it hierarchically.

## Operation
- `ins_addr` is driven combinationally from `pc`, with no extra register stage.
- Next-PC selection, in priority order:
  1. `reset` low: `pc` is set to `RESET_ADDR`.
  2. `jump` = 1: next PC is `target`.
  3. `branch` = 1: next PC is `pc + INCR + (offset << 2)`.
  4. Otherwise: next PC is `pc + INCR`.
- Jump has priority over branch when both are asserted.
- Arithmetic rules:
  - All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
  - `offset` is already sign-extended, so the `<< 2` discards its top two bits.
  - Negative offsets branch backward.
- There are no flags, no stall input and no handshake; the PC advances on every clock edge outside reset.

## Timing
- Latency is one cycle. Control and data inputs are sampled at a rising edge, and the new `ins_addr` is valid right after that edge.
- `branch`, `jump`, `offset` and `target` need only be stable around the sampling edge. A one-cycle pulse is sufficient.
- Reset behaviour:
  - Assertion is asynchronous: `ins_addr` = `RESET_ADDR` within the same timestep, independent of `clk`.
  - While `reset` is held low, `pc` stays at `RESET_ADDR` and edges are ignored.
  - Release should occur away from a rising edge. The first edge after release loads `RESET_ADDR + INCR`, or the jump/branch target if one is requested.
- Reset mid-operation discards any pending branch or jump.
- The reset value of `ins_addr` is `RESET_ADDR` (0 by default).

## Configuration
- `PC_ALIGN_EN`, when defined:
  - The low two bits of every loaded jump target are forced to 0.
  - The low two bits of `RESET_ADDR` are forced to 0.
  - Result: `pc[1:0]` is always 2'b00.
- When not defined, `target` is loaded verbatim, and unaligned PCs are possible after a jump.
- The branch path and sequential path are aligned in both configurations, provided the PC was aligned before.

## Test plan
- Reset: drive `reset` = 0 with `clk` idle → `ins_addr` = 0 immediately. Release, then apply 3 edges → 4, 8, 12.
- Branch: at `pc` = 8, pulse `branch` = 1 with `offset` = 3 for one edge → `ins_addr` = 24. The next edge with no request gives 28.
- Jump: at any `pc`, pulse `jump` = 1 with `target` = 16 → `ins_addr` = 16. The next edge gives 20.
- Priority and negative offset:
  - `jump` = 1 and `branch` = 1 together, with `target` = 64 and `offset` = 3 → 64.
  - At `pc` = 32, `branch` with `offset` = 32'hFFFF_FFFE (-2) → 28.
- Wrap-around: preload `pc` = 32'hFFFF_FFFC, apply one edge → 0.
- Mid-operation reset: assert `reset` low between edges at `pc` = 40 → 0 at once. With `PC_ALIGN_EN` defined, jump to `target` = 18 → 16.

Source files
------------

// File: rtl/program_counter.sv
// program_counter: instruction address register with sequential, branch and jump next-PC.
// Optional PC_ALIGN_EN forces jump targets and the reset address to word alignment.
module program_counter #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] INCR       = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [31:0] offset,
  input  logic        jump,
  input  logic [31:0] target,
  output logic [31:0] ins_addr
);

`ifdef PC_ALIGN_EN
  localparam logic [31:0] RST_PC = {RESET_ADDR[31:2], 2'b00};
`else
  localparam logic [31:0] RST_PC = RESET_ADDR;
`endif

  reg   [31:0] pc;
  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] jmp_pc;
  logic [31:0] next_pc;

  assign seq_pc = pc + INCR;
  // Word offset to byte offset; top two offset bits fall off.
  assign br_pc  = seq_pc + {offset[29:0], 2'b00};

`ifdef PC_ALIGN_EN
  assign jmp_pc = {target[31:2], 2'b00};
`else
  assign jmp_pc = target;
`endif

  always_comb begin
    next_pc = seq_pc;
    priority case (1'b1)
      jump:    next_pc = jmp_pc;
      branch:  next_pc = br_pc;
      default: next_pc = seq_pc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RST_PC;
    else        pc <= next_pc;
  end

  assign ins_addr = pc;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed plan plus randomized run against a next-PC model.
// Inputs change with clk low; outputs sampled 1 time unit after each rising edge.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch = 1'b0;
  logic [31:0] offset = '0;
  logic        jump = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] ins_addr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc = '0;

  program_counter dut (
    .clk      (clk),
    .reset    (reset),
    .branch   (branch),
    .offset   (offset),
    .jump     (jump),
    .target   (target),
    .ins_addr (ins_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] jmp_addr(input logic [31:0] t);
`ifdef PC_ALIGN_EN
    return t & 32'hFFFF_FFFC;
`else
    return t;
`endif
  endfunction

  // Reference: next PC computed from the selection rules with plain math.
  function automatic logic [31:0] ref_next(input logic [31:0] p,
    input logic br, input logic [31:0] off, input logic jp,
    input logic [31:0] tgt);
    logic [31:0] r;
    if (jp)      r = jmp_addr(tgt);
    else if (br) r = p + 32'd4 + off * 32'd4;
    else         r = p + 32'd4;
    return r;
  endfunction

  task automatic tick();
    #5 clk = 1'b1;
    #1;
    #4 clk = 1'b0;
  endtask

  task automatic step(input logic br, input logic [31:0] off,
                      input logic jp, input logic [31:0] tgt,
                      input string tag);
    branch = br;
    offset = off;
    jump   = jp;
    target = tgt;
    #5 clk = 1'b1;
    if (reset) m_pc = ref_next(m_pc, br, off, jp, tgt);
    #1 check(tag, ins_addr, m_pc);
    #4 clk = 1'b0;
    branch = 1'b0;
    jump   = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    #1 m_pc = 32'd0;
    check(tag, ins_addr, 32'd0);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    #1 check("reset_async", ins_addr, 32'd0);
    #2 reset = 1'b1;
    m_pc = 32'd0;
    step(0, 0, 0, 0, "seq1");
    check("seq1_abs", ins_addr, 32'd4);
    step(0, 0, 0, 0, "seq2");
    check("seq2_abs", ins_addr, 32'd8);
    step(0, 0, 0, 0, "seq3");
    check("seq3_abs", ins_addr, 32'd12);

    pulse_reset("reset_again");
    step(0, 0, 0, 0, "to4");
    step(0, 0, 0, 0, "to8");
    step(1, 32'd3, 0, 0, "branch");
    check("branch_abs", ins_addr, 32'd24);
    step(0, 0, 0, 0, "after_br");
    check("after_br_abs", ins_addr, 32'd28);

    step(0, 0, 1, 32'd16, "jump");
    check("jump_abs", ins_addr, 32'd16);
    step(0, 0, 0, 0, "after_jmp");
    check("after_jmp_abs", ins_addr, 32'd20);

    step(1, 32'd3, 1, 32'd64, "prio");
    check("prio_abs", ins_addr, 32'd64);

    step(0, 0, 1, 32'd32, "to32");
    step(1, 32'hFFFF_FFFE, 0, 0, "neg_br");
    check("neg_br_abs", ins_addr, 32'd28);

    step(0, 0, 1, 32'hFFFF_FFFC, "to_top");
    step(0, 0, 0, 0, "wrap");
    check("wrap_abs", ins_addr, 32'd0);

    step(0, 0, 1, 32'd40, "to40");
    pulse_reset("mid_reset");
    reset = 1'b0;
    branch = 1'b1;
    jump = 1'b1;
    target = 32'd100;
    tick();
    check("reset_held", ins_addr, 32'd0);
    branch = 1'b0;
    jump = 1'b0;
    #2 reset = 1'b1;
    m_pc = 32'd0;
    step(0, 0, 0, 0, "release");
    check("release_abs", ins_addr, 32'd4);

    step(0, 0, 1, 32'd18, "jump18");
`ifdef PC_ALIGN_EN
    check("jump18_abs", ins_addr, 32'd16);
`else
    check("jump18_abs", ins_addr, 32'd18);
`endif

    for (int i = 0; i < 300; i++) begin
      logic        br;
      logic        jp;
      logic [31:0] off;
      if ($urandom_range(0, 24) == 0) pulse_reset("rand_reset");
      br  = ($urandom_range(0, 2) == 0);
      jp  = ($urandom_range(0, 4) == 0);
      off = ($urandom_range(0, 1) == 0)
            ? 32'($signed($urandom_range(0, 64)) - 32)
            : $urandom;
      step(br, off, jp, $urandom, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
